// File: rtl/award_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : award_scheduler_pkg
//  Description : Shared game types for the bonus award scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package award_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_SHOW    = 3'd2,
    ST_BLINK   = 3'd3,
    ST_COLLECT = 3'd4
  } state_t;

  localparam logic [1:0] AWARD_STAR   = 2'd0;
  localparam logic [1:0] AWARD_LIFE   = 2'd1;
  localparam logic [1:0] AWARD_SHIELD = 2'd2;
  localparam logic [1:0] AWARD_BOMB   = 2'd3;

  // x^8+x^6+x^5+x^4+1 -> feedback from bits 7,5,4,3
  localparam logic [7:0] c_lfsr_taps = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & c_lfsr_taps)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/award_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : award_lfsr
//  Description : Free-running 8-bit Fibonacci LFSR, shifts left every clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module award_lfsr
  import award_scheduler_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] lfsr
);

  logic [7:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (reset) r_lfsr <= SEED;
    else       r_lfsr <= lfsr_next(r_lfsr);
  end

  assign lfsr = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/award_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : award_scheduler
//  Description : Hide/show/blink sequencing of the bonus award with
//                round-robin pickup arbitration between the two tanks.
//  Revision    : 1.0 - initial release
// ============================================================================
module award_scheduler
  import award_scheduler_pkg::*;
#(
  parameter logic [3:0] HIDE_TICKS  = 4'd10,
  parameter logic [3:0] SHOW_TICKS  = 4'd5,
  parameter logic [3:0] BLINK_TICKS = 4'd2,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       enable,
  input  logic       p1_hit,
  input  logic       p2_hit,
  output logic       award_visible,
  output logic [3:0] award_slot_x,
  output logic [3:0] award_slot_y,
  output logic [1:0] award_type,
  output logic       grant_p1,
  output logic       grant_p2,
  output logic [1:0] grant_type
);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_phase, w_phase_nxt;
  logic       r_prio, w_prio_nxt;
  logic [3:0] r_slot_x, r_slot_y;
  logic [1:0] r_type;
  logic       r_grant_p1, r_grant_p2;
  logic       w_grant_p1, w_grant_p2;
  logic       w_latch;
  logic [7:0] w_lfsr;
  logic       w_any_hit, w_p1_wins;

  award_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .lfsr  (w_lfsr)
  );

  assign w_any_hit = p1_hit | p2_hit;
  // r_prio==0 favours player 1 when both tanks touch the award together
  assign w_p1_wins = p1_hit & (~p2_hit | ~r_prio);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    w_prio_nxt  = r_prio;
    w_latch     = 1'b0;
    w_grant_p1  = 1'b0;
    w_grant_p2  = 1'b0;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = HIDE_TICKS;
        end
        ST_WAIT: begin
          if (tick) begin
            if (r_cnt == 4'd1) begin
              w_latch     = 1'b1;
              w_state_nxt = ST_SHOW;
              w_cnt_nxt   = SHOW_TICKS;
            end else begin
              w_cnt_nxt = r_cnt - 4'd1;
            end
          end
        end
        ST_SHOW, ST_BLINK: begin
          if (w_any_hit) begin
            w_state_nxt = ST_COLLECT;
            w_grant_p1  = w_p1_wins;
            w_grant_p2  = ~w_p1_wins;
            if (p1_hit & p2_hit) w_prio_nxt = ~r_prio;
          end else if (tick) begin
            if (r_cnt == 4'd1) begin
              if (r_state == ST_SHOW) begin
                w_state_nxt = ST_BLINK;
                w_cnt_nxt   = BLINK_TICKS;
                w_phase_nxt = 1'b0;
              end else begin
                w_state_nxt = ST_WAIT;
                w_cnt_nxt   = HIDE_TICKS;
              end
            end else begin
              w_cnt_nxt = r_cnt - 4'd1;
              if (r_state == ST_BLINK) w_phase_nxt = ~r_phase;
            end
          end
        end
        ST_COLLECT: begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = HIDE_TICKS;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_phase    <= 1'b0;
      r_prio     <= 1'b0;
      r_slot_x   <= 4'd0;
      r_slot_y   <= 4'd0;
      r_type     <= 2'd0;
      r_grant_p1 <= 1'b0;
      r_grant_p2 <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_phase    <= w_phase_nxt;
      r_prio     <= w_prio_nxt;
      r_grant_p1 <= w_grant_p1;
      r_grant_p2 <= w_grant_p2;
      if (w_latch) begin
        r_slot_x <= w_lfsr[3:0];
        r_slot_y <= w_lfsr[7:4];
        r_type   <= w_lfsr[5:4] ^ w_lfsr[1:0];
      end
    end
  end

  assign award_visible = (r_state == ST_SHOW) | ((r_state == ST_BLINK) & r_phase);
  assign award_slot_x  = r_slot_x;
  assign award_slot_y  = r_slot_y;
  assign award_type    = r_type;
  assign grant_p1      = r_grant_p1;
  assign grant_p2      = r_grant_p2;
  assign grant_type    = (r_grant_p1 | r_grant_p2) ? r_type : 2'd0;

endmodule
`default_nettype wire

// File: tb/tb_award_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_award_scheduler
//  Description : Directed scoreboard bench for award_scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_award_scheduler;
  import award_scheduler_pkg::*;

  logic       clk = 1'b0;
  logic       reset, tick, enable, p1_hit, p2_hit;
  logic       award_visible, grant_p1, grant_p2;
  logic [3:0] award_slot_x, award_slot_y;
  logic [1:0] award_type, grant_type;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] sb[$];
  logic [7:0] r_ref;
  logic [1:0] exp_type;

  award_scheduler #(
    .HIDE_TICKS(4'd3), .SHOW_TICKS(4'd2), .BLINK_TICKS(4'd2), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .enable(enable),
    .p1_hit(p1_hit), .p2_hit(p2_hit),
    .award_visible(award_visible), .award_slot_x(award_slot_x),
    .award_slot_y(award_slot_y), .award_type(award_type),
    .grant_p1(grant_p1), .grant_p2(grant_p2), .grant_type(grant_type)
  );

  always #5 clk = ~clk;

  // reference LFSR: taps 8,6,5,4, shift left
  always @(posedge clk) begin
    if (reset) r_ref <= 8'hA5;
    else       r_ref <= {r_ref[6:0], r_ref[7] ^ r_ref[5] ^ r_ref[4] ^ r_ref[3]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // grant monitor: pops one expected {p1,p2,type} per grant cycle
  always @(negedge clk) begin
    logic [3:0] e;
    if (grant_p1 || grant_p2) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_grant actual p1=%0b p2=%0b required none at %0t",
                 grant_p1, grant_p2, $time);
      end else begin
        e = sb.pop_front();
        chk("grant", {28'd0, grant_p1, grant_p2, grant_type}, {28'd0, e});
        chk("grant_visible", {31'd0, award_visible}, 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask

  // three hide ticks, then check the award appears at the reference slot
  task automatic appear();
    logic [7:0] s;
    do_tick();
    chk("wait_vis1", {31'd0, award_visible}, 32'd0);
    do_tick();
    chk("wait_vis2", {31'd0, award_visible}, 32'd0);
    s = r_ref;
    exp_type = s[5:4] ^ s[1:0];
    do_tick();
    chk("show_vis", {31'd0, award_visible}, 32'd1);
    chk("slot_x", {28'd0, award_slot_x}, {28'd0, s[3:0]});
    chk("slot_y", {28'd0, award_slot_y}, {28'd0, s[7:4]});
    chk("type", {30'd0, award_type}, {30'd0, exp_type});
  endtask

  task automatic hit(input logic h1, input logic h2, input logic w1, input logic w2);
    sb.push_back({w1, w2, exp_type});
    p1_hit = h1;
    p2_hit = h2;
    step();
    chk("hit_vis_drop", {31'd0, award_visible}, 32'd0);
    p1_hit = 1'b0;
    p2_hit = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit vis_pat[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    reset = 1'b1; tick = 1'b0; enable = 1'b0; p1_hit = 1'b0; p2_hit = 1'b0;
    repeat (3) step();
    chk("rst_vis", {31'd0, award_visible}, 32'd0);
    chk("rst_grant", {30'd0, grant_p1, grant_p2}, 32'd0);
    chk("rst_slot", {24'd0, award_slot_y, award_slot_x}, 32'd0);
    chk("rst_type", {30'd0, award_type}, 32'd0);
    chk("rst_lfsr", {24'd0, dut.u_lfsr.r_lfsr}, 32'hA5);

    // free-running timeline, two full 7-tick periods with no pickups
    reset = 1'b0;
    enable = 1'b1;
    step();
    for (int r = 0; r < 2; r++) begin
      appear();
      for (int i = 0; i < 4; i++) begin
        do_tick();
        chk("timeline_vis", {31'd0, award_visible}, {31'd0, vis_pat[i]});
      end
    end

    // single pickup by player 1
    appear();
    hit(1'b1, 1'b0, 1'b1, 1'b0);

    // conflicts P1, P2, P1; lone P2; next conflict goes to P2
    appear(); hit(1'b1, 1'b1, 1'b1, 1'b0);
    appear(); hit(1'b1, 1'b1, 1'b0, 1'b1);
    appear(); hit(1'b1, 1'b1, 1'b1, 1'b0);
    appear(); hit(1'b0, 1'b1, 1'b0, 1'b1);
    appear(); hit(1'b1, 1'b1, 1'b0, 1'b1);

    // hit on the final blink tick is a pickup, not a miss
    appear();
    do_tick();
    do_tick();
    chk("blink_ph0_vis", {31'd0, award_visible}, 32'd0);
    do_tick();
    chk("blink_ph1_vis", {31'd0, award_visible}, 32'd1);
    tick = 1'b1;
    hit(1'b1, 1'b0, 1'b1, 1'b0);
    tick = 1'b0;

    // hits during hide are ignored
    p1_hit = 1'b1; p2_hit = 1'b1;
    step(); step();
    p1_hit = 1'b0; p2_hit = 1'b0;
    chk("wait_hit_state", {29'd0, dut.r_state}, {29'd0, ST_WAIT});
    appear();

    // disable during show cancels the pending pickup
    p1_hit = 1'b1;
    enable = 1'b0;
    step();
    p1_hit = 1'b0;
    chk("dis_vis", {31'd0, award_visible}, 32'd0);
    chk("dis_state", {29'd0, dut.r_state}, {29'd0, ST_IDLE});
    do_tick();
    chk("dis_hold", {29'd0, dut.r_state}, {29'd0, ST_IDLE});
    enable = 1'b1;
    step();
    appear();

    // reset pulse in blink, with a hit on the same edge
    do_tick();
    do_tick();
    reset = 1'b1;
    p2_hit = 1'b1;
    step();
    chk("mid_rst_vis", {31'd0, award_visible}, 32'd0);
    chk("mid_rst_grant", {30'd0, grant_p1, grant_p2}, 32'd0);
    chk("mid_rst_slot", {26'd0, award_type, award_slot_y[0], award_slot_x[0], 2'd0} |
        {24'd0, award_slot_y, award_slot_x}, 32'd0);
    chk("mid_rst_lfsr", {24'd0, dut.u_lfsr.r_lfsr}, 32'hA5);
    reset = 1'b0;
    p2_hit = 1'b0;
    step();
    appear();

    repeat (4) step();
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
